// File: rtl/exec_muldiv_pkg.sv
// exec_muldiv_pkg: op encodings, FSM states and default width shared by the multiply/divide unit.
package exec_muldiv_pkg;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
endpackage

// File: rtl/exec_muldiv_core.sv
// exec_muldiv_core: one-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes.
module exec_muldiv_core import exec_muldiv_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_div,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic [2*DATA_W-1:0]   o_acc,
  output logic [CNT_W-1:0]      o_cnt
);
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_b;
  logic                r_div;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W:0]     w_sum, w_trial, w_diff;
  logic [2*DATA_W-1:0] w_next;
  // Upper half is the running partial product or remainder; lower half holds the multiplier or quotient bits.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_trial = r_acc[2*DATA_W-1:DATA_W-1];
    w_diff  = w_trial - {1'b0, r_b};
    w_next  = r_div ? {w_diff[DATA_W] ? w_trial[DATA_W-1:0] : w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], ~w_diff[DATA_W]}
                    : {w_sum, r_acc[DATA_W-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= {{DATA_W{1'b0}}, i_a};
      r_b   <= i_b;
      r_div <= i_div;
      r_cnt <= CNT_W'(DATA_W);
    end else if (i_step) begin
      r_acc <= w_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end
  assign o_acc = r_acc;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, single-cycle MTHI/MTLO and pipeline stall.
module exec_muldiv import exec_muldiv_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic              stall,
  input  logic              mf_req,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  state_e              r_state;
  logic                r_busy, r_done, r_na, r_nb, r_div, r_dz;
  logic [DATA_W-1:0]   r_hi, r_lo, r_rs;
  logic                w_go, w_arith, w_na, w_nb;
  logic [DATA_W-1:0]   w_ma, w_mb, w_q, w_r, w_res_hi, w_res_lo;
  logic [2*DATA_W-1:0] w_acc, w_prod;
  logic [CNT_W-1:0]    w_cnt;
  always_comb begin
    w_go     = start && !cancel && r_state == S_IDLE;
    w_arith  = !op[2];
    w_na     = (op == OP_MULT || op == OP_DIV) && rs_data[DATA_W-1];
    w_nb     = (op == OP_MULT || op == OP_DIV) && rt_data[DATA_W-1];
    w_ma     = w_na ? -rs_data : rs_data;
    w_mb     = w_nb ? -rt_data : rt_data;
    w_prod   = (r_na ^ r_nb) ? -w_acc : w_acc;
    w_q      = w_acc[DATA_W-1:0];
    w_r      = w_acc[2*DATA_W-1:DATA_W];
    // Divide by zero reports the raw dividend in HI, bypassing sign correction.
    w_res_lo = !r_div ? w_prod[DATA_W-1:0] : r_dz ? '1 : (r_na ^ r_nb) ? -w_q : w_q;
    w_res_hi = !r_div ? w_prod[2*DATA_W-1:DATA_W] : r_dz ? r_rs : r_na ? -w_r : w_r;
  end
  exec_muldiv_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk    (clock),
    .rst    (reset),
    .i_load (w_go && w_arith),
    .i_step (r_state == S_CALC && !cancel),
    .i_div  (op[1]),
    .i_a    (w_ma),
    .i_b    (w_mb),
    .o_acc  (w_acc),
    .o_cnt  (w_cnt)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_na    <= 1'b0;
      r_nb    <= 1'b0;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rs    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && w_arith) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_na    <= w_na;
            r_nb    <= w_nb;
            r_div   <= op[1];
            r_dz    <= rt_data == '0;
            r_rs    <= rs_data;
          end else if (w_go && op == OP_MTHI) r_hi <= rs_data;
          else if (w_go && op == OP_MTLO) r_lo <= rs_data;
        end
        S_CALC: begin
          if (cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_cnt == CNT_W'(1)) begin
            r_state <= S_FIX;
            r_done  <= 1'b1;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (!cancel) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy  = r_busy;
  assign done  = r_done && !cancel;
  assign stall = r_busy && (start || mf_req);
  assign hi    = r_hi;
  assign lo    = r_lo;
endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv: randomized and directed checks of exec_muldiv against a cycle-level arithmetic model.
module tb_exec_muldiv;
  localparam int W = 32;
  logic clock = 0, reset = 1, start = 0, cancel = 0, mf_req = 0;
  logic [2:0] op = 0;
  logic [W-1:0] rs_data = 0, rt_data = 0;
  logic busy, done, stall;
  logic [W-1:0] hi, lo;
  int n_cmp = 0, n_bad = 0;
  int m_rem = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0;
  logic [2*W-1:0] m_res = 0;
  logic armed = 0;

  exec_muldiv #(.DATA_W(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .cancel(cancel), .busy(busy), .done(done), .stall(stall), .mf_req(mf_req), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 3'd0) return 64'(sa * sb);
    if (o == 3'd1) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o == 3'd3) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Timeline model: an accepted arithmetic op keeps the unit busy for W+1 cycles, the last one being done.
  always @(posedge clock) begin
    armed <= 1'b1;
    if (reset) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (m_rem != 0) begin
      if (cancel) m_rem <= 0;
      else begin
        if (m_rem == 1) {m_hi, m_lo} <= m_res;
        m_rem <= m_rem - 1;
      end
    end else if (start && !cancel) begin
      if (op <= 3'd3) begin
        m_rem <= W + 1;
        m_res <= ref_op(op, rs_data, rt_data);
      end else if (op == 3'd4) m_hi <= rs_data;
      else if (op == 3'd5) m_lo <= rs_data;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) if (armed) begin
    chk("busy", busy, m_rem != 0);
    chk("done", done, m_rem == 1 && !cancel);
    chk("stall", stall, (m_rem != 0) && (start || mf_req));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int stalls);
    stalls = 0;
    start = 1; op = o; rs_data = a; rt_data = b;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clock);
      if (!stall) break;
      stalls++;
    end
    if (stalls > 100) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: stalled %0d cycles, required under 100", stalls);
    end
    @(posedge clock); #1 start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clock); n++; end while (busy && n < 100);
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    @(posedge clock); #1;
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    issue(o, a, b, s);
    wait_idle();
  endtask

  task automatic latency(input string nm);
    int n = 0;
    do begin @(negedge clock); n++; end while (!done && n < 40);
    chk(nm, n, W + 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int s;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0);

    issue(3'd0, 32'hFFFFFFFF, 32'h2, s); latency("mult_latency"); wait_idle();
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFE);
    run(3'd1, 32'hFFFFFFFF, 32'h2);
    chk("multu_hi", hi, 32'h1); chk("multu_lo", lo, 32'hFFFFFFFE);
    run(3'd2, 32'hFFFFFFF9, 32'h2);
    chk("div_hi", hi, 32'hFFFFFFFF); chk("div_lo", lo, 32'hFFFFFFFD);
    issue(3'd3, 32'h7, 32'h0, s); latency("div0_latency"); wait_idle();
    chk("div0_hi", hi, 32'h7); chk("div0_lo", lo, 32'hFFFFFFFF);
    run(3'd2, 32'hFFFFFFF9, 32'h0);
    chk("sdiv0_hi", hi, 32'hFFFFFFF9); chk("sdiv0_lo", lo, 32'hFFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, s); latency("ovf_latency"); wait_idle();
    chk("ovf_hi", hi, 32'h0); chk("ovf_lo", lo, 32'h80000000);

    issue(3'd0, 32'd3, 32'd5, s);
    repeat (4) begin @(posedge clock); #1; end
    mf_req = 1;
    issue(3'd4, 32'hCAFEBABE, 32'h0, s);
    mf_req = 0;
    chk("mthi_stalls", s, 29); chk("mthi_hi", hi, 32'hCAFEBABE); chk("mthi_lo", lo, 32'd15);

    run(3'd5, 32'h12345678, 32'h0);
    issue(3'd3, 32'd100, 32'd7, s);
    repeat (9) begin @(posedge clock); #1; end
    cancel = 1; @(posedge clock); #1 cancel = 0;
    chk("cancel_busy", busy, 0); chk("cancel_lo", lo, 32'h12345678);
    run(3'd3, 32'd100, 32'd7);
    chk("divu_lo", lo, 32'd14); chk("divu_hi", hi, 32'd2);

    issue(3'd1, 32'd9, 32'd9, s);
    repeat (32) begin @(posedge clock); #1; end
    cancel = 1; @(posedge clock); #1 cancel = 0;
    chk("fixcancel_lo", lo, 32'd14); chk("fixcancel_busy", busy, 0);

    start = 1; op = 3'd4; rs_data = 32'h55; cancel = 1;
    @(posedge clock); #1 start = 0; cancel = 0;
    chk("idle_cancel_hi", hi, 32'd2);
    run(3'd6, 32'hAA, 32'h1); run(3'd7, 32'hBB, 32'h1);
    chk("rsv_hi", hi, 32'd2); chk("rsv_lo", lo, 32'd14);

    issue(3'd0, 32'd7, 32'd9, s);
    repeat (19) begin @(posedge clock); #1; end
    reset = 1; @(posedge clock); #1 reset = 0;
    chk("mrst_hi", hi, 0); chk("mrst_lo", lo, 0); chk("mrst_busy", busy, 0);
    issue(3'd1, 32'd6, 32'd7, s);
    chk("post_rst_stalls", s, 0); chk("post_rst_busy", busy, 1);
    wait_idle();
    chk("post_rst_lo", lo, 32'd42);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      int c;
      o = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      mf_req = 1'($urandom_range(0, 1));
      issue(o, a, b, s);
      mf_req = 0;
      c = $urandom_range(0, 5);
      if (c == 0) begin
        repeat ($urandom_range(0, 34)) begin @(posedge clock); #1; end
        cancel = 1; @(posedge clock); #1 cancel = 0;
      end else if (c != 1) wait_idle();
    end
    wait_idle();
    @(posedge clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_muldiv.md
Name: exec_muldiv

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers, placed beside the single-cycle execute ALU in the Minisys execute stage.
- Executes MULT, MULTU, DIV, DIVU iteratively at one bit per cycle. Executes MTHI and MTLO in a single cycle.
- Exposes HI/LO for MFHI/MFLO and drives a stall so the pipeline holds while a result is outstanding.

Parameters:
- DATA_W, 32, operand, HI and LO width. Must be even and >= 8.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid for one cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, treated as no-op.
- rs_data  in  DATA_W  multiplicand / dividend / MT source.
- rt_data  in  DATA_W  multiplier / divisor.
- cancel  in  1  flush: aborts an in-flight operation.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse in FIX.
- stall  out  1  combinational: (start && busy) || (mf_req && busy).
- mf_req  in  1  the execute stage is issuing MFHI/MFLO this cycle.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; hi = 0, lo = 0; busy = 0; done = 0; counter = 0; working registers = 0. Reset overrides every other input, including mid-operation; a partial result is discarded.
- States:
  - IDLE -> CALC on start with op in 0..3. Latch operand magnitudes (the signed ops take the absolute value), latch the result sign, load counter = DATA_W.
  - CALC: one iteration per cycle, counter decrements. Goes to FIX when counter == 1.
  - FIX: apply the sign correction, write hi/lo, done = 1, then go to IDLE.
- Latency: start accepted at edge t. CALC occupies cycles t+1 .. t+DATA_W. FIX is cycle t+DATA_W+1. New hi/lo are visible from cycle t+DATA_W+2. Latency is fixed for all four ops, including divide by zero.
- Multiply (shift-add on magnitudes, 2*DATA_W product):
  - MULT: product negated if the operand signs differ.
  - hi = product[2*DATA_W-1:DATA_W], lo = product[DATA_W-1:0].
- Divide (restoring, on magnitudes): lo = quotient, hi = remainder.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Divisor == 0: lo = all ones, hi = rs_data (as latched), for both DIV and DIVU.
  - DIV of the most negative value by -1: lo = most negative value, hi = 0. No trap.
- MTHI/MTLO in IDLE: hi (or lo) = rs_data at the next edge. No busy, no done.
- Start while busy (any op): ignored, stall = 1. The issuer must hold the request until stall falls.
- Start in FIX: still ignored. It is accepted in the following IDLE cycle.
- mf_req while busy: stall = 1. hi/lo keep their old values until the FIX write.
- cancel:
  - In CALC or FIX: go to IDLE next edge; hi/lo unchanged; done not asserted.
  - In IDLE: no effect.
  - cancel has priority over start in the same cycle.
  - reset has priority over cancel.
- Reserved ops: no state change.

Decomposition:
- Shared package: op encodings (MULT..MTLO), state enum (IDLE, CALC, FIX), DATA_W default.
- One natural sub-module: muldiv_core. It holds the iteration datapath (product/remainder shift register, counter, add/sub step).
- exec_muldiv keeps the FSM, the sign handling, HI/LO and the stall logic.

Test Plan (DATA_W = 32):
1. MULT rs=0xFFFFFFFF, rt=0x00000002 -> done at t+33; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
2. DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007.
3. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no stall beyond the normal latency.
4. MULT issued; at t+5 assert start (MTHI) and mf_req -> stall=1 every cycle through t+33; MTHI accepted at t+34; hi equals the MTHI data at t+35.
5. MTLO 0x12345678, then DIVU 100/7 with cancel at t+10 -> busy falls at t+11, no done, lo stays 0x12345678; a following DIVU 100/7 gives lo=14, hi=2.
6. reset asserted at t+20 of a MULT -> next cycle hi=0, lo=0, busy=0, done never pulses; a start in the cycle after reset deasserts is accepted.
